bitmask_mem_req_ctrl: RTL and testbench

Request-side controller sitting directly upstream of bit_masked_memory. It accepts masked read/write requests over a valid/ready interface and buffers them in a small FIFO. It drives the memory's enb/wr/addr/data/masked inputs one transaction at a time and returns read data over a valid/ready response channel. It isolates producers from memory timing and guarantees one memory access per accepted request.

---
 rtl/bitmask_mem_req_ctrl.sv | 175 +++++++++++++++++
 tb/tb_bitmask_mem_req_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitmask_mem_req_ctrl.sv
// bitmask_mem_req_ctrl
//   Request-side controller in front of bit_masked_memory. Masked read/write
//   requests are queued in a small FIFO. An FSM issues them to the memory one
//   at a time and returns read data on a valid/ready response channel.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req_*/o_req_ready request channel (wr, addr, data, mask)
//   o_rsp_valid/data    read response, held until i_rsp_ready
//   o_mem_*             registered memory controls (enb/wr/addr/data/masked)
//   i_mem_r_data        memory read data, valid RD_LAT edges after issue
//   o_fifo_count        current FIFO occupancy
//   o_wr_count          completed writes, saturating
module bitmask_mem_req_ctrl #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int RD_LAT = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic                   i_req_wr,
    input  logic [ADDR_W-1:0]      i_req_addr,
    input  logic [DATA_W-1:0]      i_req_data,
    input  logic [DATA_W-1:0]      i_req_mask,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic [DATA_W-1:0]      o_rsp_data,
    output logic                   o_mem_enb,
    output logic                   o_mem_wr,
    output logic [ADDR_W-1:0]      o_mem_addr,
    output logic [DATA_W-1:0]      o_mem_data,
    output logic [DATA_W-1:0]      o_mem_masked,
    input  logic [DATA_W-1:0]      i_mem_r_data,
    output logic [$clog2(DEPTH):0] o_fifo_count,
    output logic [15:0]            o_wr_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LAT_W = $clog2(RD_LAT + 1);

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] mask;
    } req_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

    req_t             r_fifo [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    state_t           r_state;
    req_t             r_hold;
    logic [LAT_W-1:0] r_lat;
    logic             r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic             r_mem_enb;
    logic             r_mem_wr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data;
    logic [DATA_W-1:0] r_mem_masked;
    logic [15:0]      r_wr_count;

    logic             w_push;
    logic             w_pop;
    req_t             w_req;

    // Ready depends only on occupancy, so a pop in the same cycle never lets
    // a full FIFO take a new request.
    assign o_req_ready = !i_rst && (r_count < CNT_W'(DEPTH));
    assign w_push      = i_req_valid && o_req_ready;
    assign w_pop       = (r_state == IDLE) && (r_count != '0);
    assign w_req       = '{wr: i_req_wr, addr: i_req_addr, data: i_req_data, mask: i_req_mask};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_req;
                r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_hold       <= '0;
            r_lat        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_mem_enb    <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_mem_masked <= '0;
            r_wr_count   <= '0;
        end else begin
            // Memory controls are a one-cycle pulse; zero them everywhere
            // except on the cycle following ISSUE.
            r_mem_enb    <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_mem_masked <= '0;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_hold  <= r_fifo[r_rd_ptr];
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_mem_enb    <= 1'b1;
                    r_mem_wr     <= r_hold.wr;
                    r_mem_addr   <= r_hold.addr;
                    r_mem_data   <= r_hold.data;
                    r_mem_masked <= r_hold.mask;
                    if (r_hold.wr) begin
                        if (r_wr_count != 16'hFFFF)
                            r_wr_count <= r_wr_count + 16'd1;
                        r_state <= IDLE;
                    end else begin
                        r_lat   <= LAT_W'(RD_LAT);
                        r_state <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    // The memory samples enb one edge after ISSUE, so the
                    // counter hits zero exactly RD_LAT edges after that.
                    if (r_lat == '0) begin
                        r_rsp_data  <= i_mem_r_data;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_lat <= r_lat - LAT_W'(1);
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_data   = r_rsp_data;
    assign o_mem_enb    = r_mem_enb;
    assign o_mem_wr     = r_mem_wr;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_data   = r_mem_data;
    assign o_mem_masked = r_mem_masked;
    assign o_fifo_count = r_count;
    assign o_wr_count   = r_wr_count;

endmodule

// File: tb/tb_bitmask_mem_req_ctrl.sv
// Bench for bitmask_mem_req_ctrl: two instances (RD_LAT=1 and RD_LAT=3),
// each with its own masked memory model and issue log.
module tb_bitmask_mem_req_ctrl;
    localparam int AW = 3;
    localparam int DW = 32;
    localparam int DP = 4;
    localparam int CW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req_valid [2];
    logic          req_ready [2];
    logic          req_wr    [2];
    logic [AW-1:0] req_addr  [2];
    logic [DW-1:0] req_data  [2];
    logic [DW-1:0] req_mask  [2];
    logic          rsp_valid [2];
    logic          rsp_ready [2];
    logic [DW-1:0] rsp_data  [2];
    logic          mem_enb   [2];
    logic          mem_wr    [2];
    logic [AW-1:0] mem_addr  [2];
    logic [DW-1:0] mem_data  [2];
    logic [DW-1:0] mem_masked[2];
    logic [DW-1:0] mem_r_data[2];
    logic [CW-1:0] fifo_count[2];
    logic [15:0]   wr_count  [2];

    int checks   = 0;
    int failures = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        bitmask_mem_req_ctrl #(
            .ADDR_W(AW), .DATA_W(DW), .DEPTH(DP), .RD_LAT(g == 0 ? 1 : 3)
        ) u_dut (
            .i_clk(clk), .i_rst(rst),
            .i_req_valid(req_valid[g]), .o_req_ready(req_ready[g]),
            .i_req_wr(req_wr[g]), .i_req_addr(req_addr[g]),
            .i_req_data(req_data[g]), .i_req_mask(req_mask[g]),
            .o_rsp_valid(rsp_valid[g]), .i_rsp_ready(rsp_ready[g]),
            .o_rsp_data(rsp_data[g]),
            .o_mem_enb(mem_enb[g]), .o_mem_wr(mem_wr[g]), .o_mem_addr(mem_addr[g]),
            .o_mem_data(mem_data[g]), .o_mem_masked(mem_masked[g]),
            .i_mem_r_data(mem_r_data[g]),
            .o_fifo_count(fifo_count[g]), .o_wr_count(wr_count[g])
        );
    end

    // Memory model: read data is only valid for the single cycle it should
    // be captured in; otherwise the pipe carries a poison value.
    bit [DW-1:0] mem      [2][8];
    bit [DW-1:0] rpipe    [2][3];
    bit [AW-1:0] iss_addr [2][256];
    int          iss_n    [2];

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            rpipe[g][0] <= 32'hDEADBEEF;
            rpipe[g][1] <= rpipe[g][0];
            rpipe[g][2] <= rpipe[g][1];
            if (mem_enb[g]) begin
                iss_addr[g][iss_n[g] % 256] <= mem_addr[g];
                iss_n[g] <= iss_n[g] + 1;
                if (mem_wr[g])
                    mem[g][mem_addr[g]] <= (mem[g][mem_addr[g]] & ~mem_masked[g]) |
                                           (mem_data[g] & mem_masked[g]);
                else
                    rpipe[g][0] <= mem[g][mem_addr[g]];
            end
        end
    end
    assign mem_r_data[0] = rpipe[0][0];
    assign mem_r_data[1] = rpipe[1][2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic push(input int d, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] dt, input logic [DW-1:0] mk);
        int t = 0;
        req_valid[d] = 1'b1; req_wr[d] = w; req_addr[d] = a;
        req_data[d]  = dt;   req_mask[d] = mk;
        while (!req_ready[d] && t < 200) begin @(negedge clk); t++; end
        chk("push_accept", req_ready[d], 1'b1);
        @(negedge clk);
        req_valid[d] = 1'b0;
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] mask;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t vt [12];

    // Single transaction into an idle instance 0 (RD_LAT=1). Sample i is
    // taken at the negedge after edge E_i, E0 being the accept edge.
    task automatic run_vec(input vec_t v, input int idx);
        int en_n = 0, en_at = -1, rv_at = -1;
        logic [DW-1:0] rv_d = '0;
        logic [15:0]   wc0  = wr_count[0];
        chk($sformatf("vec%0d_ready", idx), req_ready[0], 1'b1);
        req_valid[0] = 1'b1; req_wr[0] = v.wr; req_addr[0] = v.addr;
        req_data[0]  = v.data; req_mask[0] = v.mask;
        @(negedge clk);
        req_valid[0] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (mem_enb[0]) begin
                en_n++; en_at = i;
                chk($sformatf("vec%0d_mem_wr", idx), mem_wr[0], v.wr);
                chk($sformatf("vec%0d_mem_addr", idx), mem_addr[0], v.addr);
                chk($sformatf("vec%0d_mem_data", idx), mem_data[0], v.data);
                chk($sformatf("vec%0d_mem_masked", idx), mem_masked[0], v.mask);
            end else begin
                chk($sformatf("vec%0d_mem_idle", idx),
                    mem_wr[0] || mem_addr[0] != '0 || mem_data[0] != '0 || mem_masked[0] != '0, 1'b0);
            end
            if (rsp_valid[0] && rv_at < 0) begin rv_at = i; rv_d = rsp_data[0]; end
            @(negedge clk);
        end
        chk($sformatf("vec%0d_enb_count", idx), en_n, 1);
        chk($sformatf("vec%0d_enb_cycle", idx), en_at, 2);
        if (v.wr) begin
            chk($sformatf("vec%0d_wr_count", idx), wr_count[0], wc0 + 16'd1);
            chk($sformatf("vec%0d_no_rsp", idx), rv_at, -1);
        end else begin
            chk($sformatf("vec%0d_wr_count", idx), wr_count[0], wc0);
            chk($sformatf("vec%0d_rsp_cycle", idx), rv_at, 4);
            chk($sformatf("vec%0d_rsp_data", idx), rv_d, v.exp);
        end
    endtask

    // Random traffic against a shadow memory. Requests are modelled at the
    // negedge before their accept edge; responses are checked likewise.
    task automatic rand_run(input int d, input int n);
        bit   [DW-1:0] sh [8];
        logic [DW-1:0] expq [$];
        int sent = 0, nwr = 0, nrd = 0, got = 0, t = 0, base_iss = iss_n[d];
        logic [15:0] wc0 = wr_count[d];
        logic pend = 1'b0, acc = 1'b0;
        logic w; logic [AW-1:0] a; logic [DW-1:0] dt, mk;
        while (t < 20000 && (sent < n || got < nrd)) begin
            if (acc) begin req_valid[d] = 1'b0; acc = 1'b0; end
            rsp_ready[d] = ($urandom_range(3) != 0);
            if (rsp_valid[d] && rsp_ready[d]) begin
                if (expq.size() == 0) chk("rand_extra_rsp", 1'b1, 1'b0);
                else chk($sformatf("rand%0d_rsp_data", d), rsp_data[d], expq.pop_front());
                got++;
            end
            if (!pend && sent < n && $urandom_range(2) != 0) begin
                if (sent < 8) begin
                    w = 1'b1; a = AW'(sent); mk = '1;
                end else begin
                    w = $urandom_range(1) == 1; a = AW'($urandom_range(7)); mk = $urandom;
                end
                dt = $urandom;
                req_valid[d] = 1'b1; req_wr[d] = w; req_addr[d] = a;
                req_data[d] = dt; req_mask[d] = mk;
                pend = 1'b1;
            end
            if (pend && req_ready[d]) begin
                if (w) begin sh[a] = (sh[a] & ~mk) | (dt & mk); nwr++; end
                else begin expq.push_back(sh[a]); nrd++; end
                sent++; pend = 1'b0; acc = 1'b1;
            end
            @(negedge clk); t++;
        end
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
        chk($sformatf("rand%0d_timeout", d), t < 20000, 1'b1);
        repeat (10) @(negedge clk);
        chk($sformatf("rand%0d_wr_count", d), wr_count[d] - wc0, nwr);
        chk($sformatf("rand%0d_issues", d), iss_n[d] - base_iss, n);
    endtask

    initial begin
        int b0, b1, t, rv;
        logic [DW-1:0] rvd;
        logic [AW-1:0] ea [6];

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_wr[d] = 1'b0; req_addr[d] = '0;
            req_data[d] = '0; req_mask[d] = '0; rsp_ready[d] = 1'b0;
        end
        vt[0]  = '{1'b1, 3'd3, 32'h0000003F, 32'h000003FF, 32'h0};
        vt[1]  = '{1'b1, 3'd1, 32'hFFFFFFFF, 32'h0000FFFF, 32'h0};
        vt[2]  = '{1'b0, 3'd1, 32'h0,        32'h0,        32'h0000FFFF};
        vt[3]  = '{1'b1, 3'd1, 32'h12345678, 32'hFFFF0000, 32'h0};
        vt[4]  = '{1'b0, 3'd1, 32'h0,        32'h0,        32'h1234FFFF};
        vt[5]  = '{1'b0, 3'd3, 32'h0,        32'h0,        32'h0000003F};
        vt[6]  = '{1'b1, 3'd7, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'h0};
        vt[7]  = '{1'b1, 3'd7, 32'h00000000, 32'h0000000F, 32'h0};
        vt[8]  = '{1'b0, 3'd7, 32'h0,        32'h0,        32'hA5A5A5A0};
        vt[9]  = '{1'b0, 3'd0, 32'h0,        32'h0,        32'h00000000};
        vt[10] = '{1'b1, 3'd0, 32'hFFFFFFFF, 32'h00000000, 32'h0};
        vt[11] = '{1'b0, 3'd0, 32'h0,        32'h0,        32'h00000000};

        // Reset state
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_req_ready", req_ready[d], 1'b0);
            chk("rst_fifo_count", fifo_count[d], 0);
            chk("rst_rsp_valid", rsp_valid[d], 1'b0);
            chk("rst_rsp_data", rsp_data[d], 0);
            chk("rst_mem_enb", mem_enb[d], 1'b0);
            chk("rst_wr_count", wr_count[d], 0);
        end
        rst = 1'b0;
        #1;
        chk("rel_req_ready0", req_ready[0], 1'b1);
        chk("rel_req_ready1", req_ready[1], 1'b1);
        @(negedge clk);

        // Directed single transactions
        rsp_ready[0] = 1'b1;
        for (int i = 0; i < 12; i++) run_vec(vt[i], i);

        // Back-pressure: read stalls in RESP while writes fill the FIFO
        rsp_ready[0] = 1'b0;
        b0 = iss_n[0];
        push(0, 1'b0, 3'd1, 32'h0, 32'h0);
        t = 0;
        while (!rsp_valid[0] && t < 20) begin @(negedge clk); t++; end
        chk("bp_rsp_seen", rsp_valid[0], 1'b1);
        push(0, 1'b1, 3'd2, 32'h22222222, 32'hFFFFFFFF);
        push(0, 1'b1, 3'd4, 32'h44444444, 32'hFFFFFFFF);
        push(0, 1'b1, 3'd5, 32'h55555555, 32'hFFFFFFFF);
        push(0, 1'b1, 3'd6, 32'h66666666, 32'hFFFFFFFF);
        chk("bp_full_count", fifo_count[0], 4);
        req_valid[0] = 1'b1; req_wr[0] = 1'b1; req_addr[0] = 3'd0;
        req_data[0] = 32'h0; req_mask[0] = 32'h0;
        for (int i = 0; i < 10; i++) begin
            chk("bp_ready_low", req_ready[0], 1'b0);
            chk("bp_count_hold", fifo_count[0], 4);
            chk("bp_rsp_valid", rsp_valid[0], 1'b1);
            chk("bp_rsp_data", rsp_data[0], 32'h1234FFFF);
            chk("bp_no_issue", iss_n[0] - b0, 1);
            @(negedge clk);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        chk("bp_rsp_cleared", rsp_valid[0], 1'b0);
        chk("bp_no_push_yet", fifo_count[0], 4);
        @(negedge clk);
        chk("bp_after_pop", fifo_count[0], 3);
        chk("bp_ready_back", req_ready[0], 1'b1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk("bp_fifth_accepted", fifo_count[0], 4);
        t = 0;
        while (iss_n[0] - b0 < 6 && t < 60) begin @(negedge clk); t++; end
        ea = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd0};
        for (int k = 0; k < 6; k++)
            chk($sformatf("bp_order%0d", k), iss_addr[0][(b0 + k) % 256], ea[k]);
        repeat (4) @(negedge clk);
        chk("bp_total_issues", iss_n[0] - b0, 6);

        // Reset during WAIT_RD on instance 1 (RD_LAT=3), two requests queued
        rsp_ready[1] = 1'b1;
        b1 = iss_n[1];
        req_valid[1] = 1'b1; req_wr[1] = 1'b0; req_addr[1] = 3'd3;
        @(negedge clk);
        req_wr[1] = 1'b1; req_addr[1] = 3'd4; req_data[1] = 32'h1; req_mask[1] = 32'h1;
        @(negedge clk);
        req_addr[1] = 3'd5;
        @(negedge clk);
        req_valid[1] = 1'b0;
        chk("mr_issue_enb", mem_enb[1], 1'b1);
        chk("mr_queued", fifo_count[1], 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_fifo_count", fifo_count[1], 0);
        chk("mr_rsp_valid", rsp_valid[1], 1'b0);
        chk("mr_mem_enb", mem_enb[1], 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("mr_quiet_rsp", rsp_valid[1], 1'b0);
            chk("mr_quiet_enb", mem_enb[1], 1'b0);
            @(negedge clk);
        end
        chk("mr_issues", iss_n[1] - b1, 1);
        chk("mr_wr_count", wr_count[1], 0);

        // Read latency with RD_LAT=3: rsp_valid at E3+3
        push(1, 1'b1, 3'd5, 32'hCAFEF00D, 32'hFFFF00FF);
        repeat (6) @(negedge clk);
        chk("lat3_wr_count", wr_count[1], 1);
        req_valid[1] = 1'b1; req_wr[1] = 1'b0; req_addr[1] = 3'd5;
        @(negedge clk);
        req_valid[1] = 1'b0;
        rv = -1; rvd = '0;
        for (int i = 0; i < 12; i++) begin
            if (rsp_valid[1] && rv < 0) begin rv = i; rvd = rsp_data[1]; end
            @(negedge clk);
        end
        chk("lat3_rsp_cycle", rv, 6);
        chk("lat3_rsp_data", rvd, 32'hCAFE000D);

        // Random traffic on both latencies
        fork
            rand_run(0, 200);
            rand_run(1, 200);
        join

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
